pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/pipe_ctrl.sv | 103 ++++++++++
 tb/tb_pipe_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall encodings, ERET code,
// the default exception vector and FSM state encodings.
package pipe_ctrl_pkg;

    localparam int unsigned STALL_W = 6;
    localparam int unsigned ADDR_W  = 32;

    // Per-stage stall bit values
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Stall vectors: a request from a stage freezes that stage and everything upstream
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    localparam logic [ADDR_W-1:0] EXC_ERET           = 32'h0000000e;
    localparam logic [ADDR_W-1:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline controller: resolves stall requests into a prefix stall vector,
// converts a committed mem-stage exception into flush + PC redirect, holds the
// redirect while an instruction fetch is outstanding, and counts stall cycles.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   stallreq_if/id/ex/mem          per-stage stall requests
//   excepttype_i, cp0_epc_i        mem-stage exception code, forwarded EPC
//   if_accept                      PC stage takes redirect_pc this cycle
//   stall[5:0], flush              pipeline register controls (combinational)
//   redirect_valid, redirect_pc    fetch redirect (combinational)
//   stall_cycles                   registered count of cycles with stall[0]=1
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      cp0_epc_i,
    input  logic             if_accept,
    output logic [5:0]       stall,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] stall_cycles
);

    state_e      state;
    state_e      next_state;
    logic [31:0] pend_pc;
    logic        latch_pend;

    // State, pending redirect target and stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            pend_pc      <= 32'h0;
            stall_cycles <= '0;
        end else begin
            state <= next_state;
            if (latch_pend) begin
                pend_pc <= redirect_pc;
            end
            if (stall[0] == Stop) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

    // Next state and combinational pipeline controls; everything is zero under reset
    always_comb begin
        next_state     = state;
        stall          = STALL_NONE;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        latch_pend     = 1'b0;

        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (excepttype_i != 32'h0) begin
                        // Flush overrides every stall request
                        flush          = 1'b1;
                        redirect_valid = 1'b1;
                        redirect_pc    = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
                        if (!if_accept) begin
                            latch_pend = 1'b1;
                            next_state = REDIRECT;
                        end
                    end else if (stallreq_mem) begin
                        stall = STALL_MEM;
                    end else if (stallreq_ex) begin
                        stall = STALL_EX;
                    end else if (stallreq_id) begin
                        stall = STALL_ID;
                    end else if (stallreq_if) begin
                        stall = STALL_IF;
                    end
                end
                REDIRECT: begin
                    // Pipeline holds only bubbles; new requests are ignored until fetch takes the PC
                    stall          = STALL_IF;
                    redirect_valid = 1'b1;
                    redirect_pc    = pend_pc;
                    if (if_accept) begin
                        next_state = RUN;
                    end
                end
                default: begin
                    next_state = RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a stimulus process drives inputs and pushes
// the reference model's expected outputs; a monitor pops and compares them.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] excepttype_i, cp0_epc_i;
    logic        if_accept;

    logic [5:0]  stall;
    logic        flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] stall_cycles;

    logic [5:0]  stall_s;
    logic        flush_s, redirect_valid_s;
    logic [31:0] redirect_pc_s;
    logic [3:0]  stall_cycles_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i), .if_accept(if_accept),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .stall_cycles(stall_cycles)
    );

    // Narrow-counter instance so counter wrap is reachable in a short run
    pipe_ctrl #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i), .if_accept(if_accept),
        .stall(stall_s), .flush(flush_s), .redirect_valid(redirect_valid_s),
        .redirect_pc(redirect_pc_s), .stall_cycles(stall_cycles_s)
    );

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] cnt;
        logic        chk_cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    bit          m_pending = 1'b0;
    logic [31:0] m_pend_pc = 32'h0;
    logic [31:0] m_cnt     = 32'h0;
    bit          m_cnt_known = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs just after posedge, predict outputs and next model state
    task automatic drive(input logic r, input logic sif, input logic sid, input logic sex,
                         input logic smem, input logic [31:0] exc, input logic [31:0] epc,
                         input logic acc);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        rst = r; stallreq_if = sif; stallreq_id = sid; stallreq_ex = sex; stallreq_mem = smem;
        excepttype_i = exc; cp0_epc_i = epc; if_accept = acc;

        e.stall = 6'h0; e.flush = 1'b0; e.rv = 1'b0; e.rpc = 32'h0;
        e.cnt = m_cnt; e.chk_cnt = m_cnt_known;
        if (r) begin
            m_pending   = 1'b0;
            m_pend_pc   = 32'h0;
            m_cnt       = 32'h0;
            m_cnt_known = 1'b1;
        end else begin
            if (m_pending) begin
                e.stall = 6'b000011; e.rv = 1'b1; e.rpc = m_pend_pc;
                if (acc) m_pending = 1'b0;
            end else if (exc != 32'h0) begin
                e.flush = 1'b1; e.rv = 1'b1;
                e.rpc = (exc == 32'he) ? epc : 32'hBFC00380;
                if (!acc) begin
                    m_pending = 1'b1;
                    m_pend_pc = e.rpc;
                end
            end else begin
                // Number of frozen stages counted from the pc end
                n = smem ? 5 : sex ? 4 : sid ? 3 : sif ? 2 : 0;
                e.stall = 6'((1 << n) - 1);
            end
            if (e.stall[0]) m_cnt = m_cnt + 32'd1;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    endtask

    // Monitor: outputs are presented every cycle; compare on the falling edge
    initial begin
        exp_t e;
        logic [31:0] small_req;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("stall", 32'(stall), 32'(e.stall));
                chk("flush", 32'(flush), 32'(e.flush));
                chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
                chk("redirect_pc", redirect_pc, e.rpc);
                if (e.chk_cnt) begin
                    small_req = e.cnt & 32'hF;
                    chk("stall_cycles", stall_cycles, e.cnt);
                    chk("stall_cycles_w4", 32'(stall_cycles_s), small_req);
                end
            end
        end
    end

    initial begin
        int drain;
        logic [31:0] codes [4];
        logic [31:0] exc;
        codes[0] = 32'h8; codes[1] = 32'hc; codes[2] = 32'he; codes[3] = 32'h4;

        rst = 1'b1; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        excepttype_i = 0; cp0_epc_i = 0; if_accept = 0;

        // Reset and idle, then a 3-cycle load-use stall
        drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 0);
        drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 0);
        idle(2);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 32'h0, 32'h0, 0);
        idle(1);

        // Simultaneous requests: highest stage wins
        drive(0, 1, 1, 0, 1, 32'h0, 32'h0, 0);
        drive(0, 0, 1, 1, 0, 32'h0, 32'h0, 1);
        drive(0, 1, 0, 0, 0, 32'h0, 32'h0, 0);

        // Exception with idle fetch, alongside a data stall
        drive(0, 0, 0, 0, 1, 32'h8, 32'h1234, 1);
        idle(1);

        // ERET with fetch busy, a new exception while redirecting, then accept
        drive(0, 0, 0, 0, 0, 32'he, 32'hBFC00100, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 32'he, 32'hBFC00100, 0);
        drive(0, 0, 0, 0, 1, 32'hc, 32'h5555, 0);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
        idle(1);

        // Reset in the middle of a redirect drops it
        drive(0, 0, 0, 0, 0, 32'h8, 32'h0, 0);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
        drive(1, 0, 1, 0, 0, 32'h8, 32'h0, 1);
        idle(1);

        // 16 stall cycles: the 4-bit counter wraps to 0
        for (int i = 0; i < 16; i++) drive(0, 1, 0, 0, 0, 32'h0, 32'h0, 0);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            exc = ($urandom_range(0, 7) == 0) ? codes[$urandom_range(0, 3)] : 32'h0;
            drive(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), exc, $urandom, ($urandom_range(0, 3) == 0));
        end

        drain = 0;
        while (exp_q.size() != 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        @(posedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
